// File: rtl/layer_tile_scheduler_pkg.sv
// rtl/layer_tile_scheduler_pkg.sv - shared types, widths and helpers for the CNN layer tile scheduler
// Package cnn_ctrl_pkg: FSM state enum, field widths, ceil-divide-by-power-of-two helper.
package cnn_ctrl_pkg;

  localparam int IFM_SIZE_W = 9;
  localparam int CH_W       = 11;
  localparam int PERF_W     = 32;
  // Tile arithmetic runs one bit wider than the widest dimension so base+step and
  // dim-base never wrap.
  localparam int CALC_W     = 12;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    WAIT,
    NEXT,
    DONE
  } state_t;

  // ceil(dim / 2**lg) by shift-and-round-up.
  function automatic logic [CALC_W-1:0] ceil_groups(input logic [CALC_W-1:0] dim,
                                                    input int unsigned lg);
    logic [CALC_W-1:0] round_up;
    round_up = (CALC_W'(1) << lg) - CALC_W'(1);
    return (dim + round_up) >> lg;
  endfunction

endpackage

// File: rtl/layer_tile_scheduler_if.sv
// rtl/layer_tile_scheduler_if.sv - layer-control and tile-issue signal bundle
// Ports (master = scheduler side):
//   in : start_layer, ifm_size, ifm_channel, num_filter, done_tile
//   out: done_layer, busy, start_tile, filter/row/channel base+valid,
//        first_channel, last_channel, tile_count, cycle_count
interface layer_tile_scheduler_if #(
  parameter int PE_COLS  = 16,
  parameter int CH_TILE  = 16,
  parameter int ROW_TILE = 16
);
  import cnn_ctrl_pkg::*;

  localparam int FV_W = $clog2(PE_COLS + 1);
  localparam int RV_W = $clog2(ROW_TILE + 1);
  localparam int CV_W = $clog2(CH_TILE + 1);

  logic                  start_layer;
  logic [IFM_SIZE_W-1:0] ifm_size;
  logic [CH_W-1:0]       ifm_channel;
  logic [CH_W-1:0]       num_filter;
  logic                  done_layer;
  logic                  busy;
  logic                  start_tile;
  logic                  done_tile;
  logic [CH_W-1:0]       filter_base;
  logic [FV_W-1:0]       filter_valid;
  logic [IFM_SIZE_W-1:0] row_base;
  logic [RV_W-1:0]       row_valid;
  logic [CH_W-1:0]       channel_base;
  logic [CV_W-1:0]       channel_valid;
  logic                  first_channel;
  logic                  last_channel;
  logic [PERF_W-1:0]     tile_count;
  logic [PERF_W-1:0]     cycle_count;

  modport master (
    input  start_layer, ifm_size, ifm_channel, num_filter, done_tile,
    output done_layer, busy, start_tile, filter_base, filter_valid, row_base, row_valid,
           channel_base, channel_valid, first_channel, last_channel, tile_count, cycle_count
  );

  modport slave (
    output start_layer, ifm_size, ifm_channel, num_filter, done_tile,
    input  done_layer, busy, start_tile, filter_base, filter_valid, row_base, row_valid,
           channel_base, channel_valid, first_channel, last_channel, tile_count, cycle_count
  );

endinterface

// File: rtl/layer_tile_scheduler_tile_loop_cnt.sv
// rtl/layer_tile_scheduler_tile_loop_cnt.sv - one tiling loop: index/base counter with wrap
// Ports:
//   clk, rst_n      clock, async active-low reset
//   clear           zero index and base
//   advance         step to next group, wrapping to 0 after the last group
//   dim, groups     loop dimension and its group count (limit)
//   base            first element of the current group
//   valid           elements in the current group, min(STEP, dim-base)
//   last            current group is the last one
module tile_loop_cnt
  import cnn_ctrl_pkg::*;
#(
  parameter int DIM_W   = 11,
  parameter int STEP    = 16,
  parameter int VALID_W = $clog2(STEP + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               advance,
  input  logic [DIM_W-1:0]   dim,
  input  logic [DIM_W-1:0]   groups,
  output logic [DIM_W-1:0]   base,
  output logic [VALID_W-1:0] valid,
  output logic               last
);

  logic [DIM_W-1:0]  idx_q, idx_d;
  logic [DIM_W-1:0]  base_q, base_d;
  logic [CALC_W-1:0] remain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      base_q <= '0;
    end else begin
      idx_q  <= idx_d;
      base_q <= base_d;
    end
  end

  always_comb begin
    idx_d  = idx_q;
    base_d = base_q;
    if (clear) begin
      idx_d  = '0;
      base_d = '0;
    end else if (advance) begin
      if (last) begin
        idx_d  = '0;
        base_d = '0;
      end else begin
        idx_d  = idx_q + DIM_W'(1);
        base_d = base_q + DIM_W'(STEP);
      end
    end
  end

  assign last   = (idx_q == groups - DIM_W'(1));
  assign remain = CALC_W'(dim) - CALC_W'(base_q);
  assign valid  = (remain > CALC_W'(STEP)) ? VALID_W'(STEP) : VALID_W'(remain);
  assign base   = base_q;

endmodule

// File: rtl/layer_tile_scheduler.sv
// rtl/layer_tile_scheduler.sv - sequences one CNN layer as filter/row/channel tiles on the PE array
// Ports:
//   clk, rst_n  clock, async active-low reset
//   bus         layer_tile_scheduler_if.master: layer start/done + config, tile start/done + fields,
//               perf counters
// Config macro: PERF_COUNT_EN enables tile_count/cycle_count; otherwise both read 0.
module layer_tile_scheduler
  import cnn_ctrl_pkg::*;
#(
  parameter int PE_COLS  = 16,
  parameter int CH_TILE  = 16,
  parameter int ROW_TILE = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  layer_tile_scheduler_if.master bus
);

  localparam int F_LG = $clog2(PE_COLS);
  localparam int R_LG = $clog2(ROW_TILE);
  localparam int C_LG = $clog2(CH_TILE);
  localparam int FV_W = $clog2(PE_COLS + 1);
  localparam int RV_W = $clog2(ROW_TILE + 1);
  localparam int CV_W = $clog2(CH_TILE + 1);

  state_t                state_q, state_d;
  logic [IFM_SIZE_W-1:0] ifm_size_q, ifm_size_d;
  logic [CH_W-1:0]       ifm_channel_q, ifm_channel_d;
  logic [CH_W-1:0]       num_filter_q, num_filter_d;
  logic [CH_W-1:0]       f_groups_q, f_groups_d;
  logic [IFM_SIZE_W-1:0] r_groups_q, r_groups_d;
  logic [CH_W-1:0]       c_groups_q, c_groups_d;

  logic                  loop_clear, f_adv, r_adv, c_adv;
  logic                  f_last, r_last, c_last;
  logic [CH_W-1:0]       f_base, c_base;
  logic [IFM_SIZE_W-1:0] r_base;
  logic [FV_W-1:0]       f_valid;
  logic [RV_W-1:0]       r_valid;
  logic [CV_W-1:0]       c_valid;
  logic                  start_tile, done_layer, busy, tile_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ifm_size_q    <= '0;
      ifm_channel_q <= '0;
      num_filter_q  <= '0;
      f_groups_q    <= '0;
      r_groups_q    <= '0;
      c_groups_q    <= '0;
    end else begin
      state_q       <= state_d;
      ifm_size_q    <= ifm_size_d;
      ifm_channel_q <= ifm_channel_d;
      num_filter_q  <= num_filter_d;
      f_groups_q    <= f_groups_d;
      r_groups_q    <= r_groups_d;
      c_groups_q    <= c_groups_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ifm_size_d    = ifm_size_q;
    ifm_channel_d = ifm_channel_q;
    num_filter_d  = num_filter_q;
    f_groups_d    = f_groups_q;
    r_groups_d    = r_groups_q;
    c_groups_d    = c_groups_q;
    loop_clear    = 1'b0;
    f_adv         = 1'b0;
    r_adv         = 1'b0;
    c_adv         = 1'b0;
    start_tile    = 1'b0;
    done_layer    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_layer) begin
          ifm_size_d    = bus.ifm_size;
          ifm_channel_d = bus.ifm_channel;
          num_filter_d  = bus.num_filter;
          state_d       = LOAD;
        end
      end
      LOAD: begin
        loop_clear = 1'b1;
        f_groups_d = CH_W'(ceil_groups(CALC_W'(num_filter_q), F_LG));
        r_groups_d = IFM_SIZE_W'(ceil_groups(CALC_W'(ifm_size_q), R_LG));
        c_groups_d = CH_W'(ceil_groups(CALC_W'(ifm_channel_q), C_LG));
        if ((ifm_size_q == '0) || (ifm_channel_q == '0) || (num_filter_q == '0)) begin
          state_d = DONE;
        end else begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        start_tile = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        if (bus.done_tile) begin
          state_d = (f_last && r_last && c_last) ? DONE : NEXT;
        end
      end
      NEXT: begin
        // Channel is the innermost loop; outer loops step only when the inner one wraps.
        c_adv   = 1'b1;
        r_adv   = c_last;
        f_adv   = c_last && r_last;
        state_d = ISSUE;
      end
      DONE: begin
        done_layer = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  tile_loop_cnt #(.DIM_W(CH_W), .STEP(PE_COLS), .VALID_W(FV_W)) u_filter_loop (
    .clk(clk), .rst_n(rst_n), .clear(loop_clear), .advance(f_adv),
    .dim(num_filter_q), .groups(f_groups_q),
    .base(f_base), .valid(f_valid), .last(f_last)
  );

  tile_loop_cnt #(.DIM_W(IFM_SIZE_W), .STEP(ROW_TILE), .VALID_W(RV_W)) u_row_loop (
    .clk(clk), .rst_n(rst_n), .clear(loop_clear), .advance(r_adv),
    .dim(ifm_size_q), .groups(r_groups_q),
    .base(r_base), .valid(r_valid), .last(r_last)
  );

  tile_loop_cnt #(.DIM_W(CH_W), .STEP(CH_TILE), .VALID_W(CV_W)) u_channel_loop (
    .clk(clk), .rst_n(rst_n), .clear(loop_clear), .advance(c_adv),
    .dim(ifm_channel_q), .groups(c_groups_q),
    .base(c_base), .valid(c_valid), .last(c_last)
  );

  assign busy       = (state_q == LOAD) || (state_q == ISSUE) ||
                      (state_q == WAIT) || (state_q == NEXT);
  // first/last flags only mean something while a tile is in flight; keep them low otherwise
  // so reset and idle read as 0.
  assign tile_phase = (state_q == ISSUE) || (state_q == WAIT) || (state_q == NEXT);

  assign bus.start_tile    = start_tile;
  assign bus.done_layer    = done_layer;
  assign bus.busy          = busy;
  assign bus.filter_base   = f_base;
  assign bus.filter_valid  = f_valid;
  assign bus.row_base      = r_base;
  assign bus.row_valid     = r_valid;
  assign bus.channel_base  = c_base;
  assign bus.channel_valid = c_valid;
  // Channel base is 0 exactly for channel group 0.
  assign bus.first_channel = tile_phase && (c_base == '0);
  assign bus.last_channel  = tile_phase && c_last;

`ifdef PERF_COUNT_EN
  logic [PERF_W-1:0] tile_count_q, tile_count_d;
  logic [PERF_W-1:0] cycle_count_q, cycle_count_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_count_q  <= '0;
      cycle_count_q <= '0;
    end else begin
      tile_count_q  <= tile_count_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  always_comb begin
    tile_count_d  = tile_count_q;
    cycle_count_d = cycle_count_q;
    if ((state_q == IDLE) && bus.start_layer) begin
      tile_count_d  = '0;
      cycle_count_d = '0;
    end else begin
      if (start_tile) tile_count_d = tile_count_q + PERF_W'(1);
      if (busy)       cycle_count_d = cycle_count_q + PERF_W'(1);
    end
  end

  assign bus.tile_count  = tile_count_q;
  assign bus.cycle_count = cycle_count_q;
`else
  assign bus.tile_count  = '0;
  assign bus.cycle_count = '0;
`endif

endmodule
